match_controller: RTL and testbench
===================================

// Module: match_controller
// PURPOSE
//  Sequences a best-of-N tug-of-war match: tracks per-player round wins,
//  resets and enables the playfield between rounds, and declares the winner.
//  Sits between the playfield (which emits round-win pulses) and the two score 7-seg displays.
//  All outputs are decoded from registered state; no combinational input->output path.
// PARAMETERS
//  WIN_SCORE    3  rounds needed to win the match; legal range 1..7
//  HOLD_CYCLES  4  cycles field_reset is held between rounds (>=1)
// PORTS
//  Clock        in   1  sole clock; everything is posedge Clock
//  Reset        in   1  synchronous, active-high; sampled on posedge Clock only
//  start        in   1  one-cycle pulse, already synchronised: begin or restart a match
//  left_win     in   1  one-cycle pulse from playfield: left player took the round
//  right_win    in   1  one-cycle pulse from playfield: right player took the round
//  field_reset  out  1  holds the playfield in its reset/centre position
//  play_en      out  1  playfield may accept player presses
//  left_hex     out  7  left score, active-low segments {g,f,e,d,c,b,a}
//  right_hex    out  7  right score, same encoding
//  match_done   out  1  match finished; winner valid
//  winner       out  1  0=left, 1=right; meaningful only while match_done=1
// BEHAVIOUR
//  Reset: state=IDLE, scores=0, hold count=0; field_reset=1, play_en=0,
//   left_hex=right_hex=7'b1000000 ("0"), match_done=0, winner=0. Reset overrides all inputs.
//  States: IDLE, PLAY, ROUND_END, MATCH_OVER.
//  IDLE: field_reset=1, play_en=0. start -> PLAY on the next edge. Win pulses ignored.
//  PLAY: field_reset=0, play_en=1.
//   left_win only: left score +1; new score==WIN_SCORE -> MATCH_OVER, winner=0; else -> ROUND_END.
//   right_win only: symmetric, winner=1.
//   Both same cycle: draw; no score change; -> ROUND_END.
//   start in PLAY: ignored.
//  ROUND_END: field_reset=1, play_en=0 for exactly HOLD_CYCLES cycles, then -> PLAY.
//   Win pulses and start ignored.
//  MATCH_OVER: field_reset=1, play_en=0, match_done=1; scores frozen on display.
//   start -> scores cleared, match_done=0, -> PLAY (next edge).
//  Latency: win pulse at edge N -> hex, state and field_reset updated after edge N.
//   play_en=0 from that edge onward.
//  Scores saturate at WIN_SCORE and are never incremented outside PLAY.
//  Reset mid-round/mid-hold: immediate return to reset values; hold count cleared.
//  7-seg map: 0=1000000 1=1111001 2=0100100 3=0110000
//   4=0011001 5=0010010 6=0000010 7=1111000.
// CONFIGURATION
//  MATCH_AUTO_RESTART_EN defined: MATCH_OVER lasts 8*HOLD_CYCLES cycles,
//   then scores are cleared, match_done=0, -> IDLE. start during that window restarts
//   exactly as without the macro.
//  Not defined: MATCH_OVER persists until start or Reset.
// STRUCTURE
//  Package tug_pkg: match_state_t enum {IDLE,PLAY,ROUND_END,MATCH_OVER};
//   SEG_0..SEG_7 localparams; SEG_BLANK=7'b1111111 for out-of-range values.
//  Sub-module seg7_decoder (3-bit value -> 7-bit active-low), instantiated once per player.
//  Hold/auto-restart timer and score registers are inline in match_controller.
// TESTING
//  Reset 2 cycles, no start -> field_reset=1, play_en=0, both hex=1000000, match_done=0.
//  start, then left_win at 1 cycle -> left_hex=1111001, field_reset=1 for 4 cycles,
//   then play_en=1.
//  In PLAY: left_win and right_win same cycle -> both hex unchanged; ROUND_END 4 cycles.
//  Win sequence R,R,L,R -> right_hex=0110000, left_hex=1111001, match_done=1, winner=1;
//   further win pulses change nothing.
//  MATCH_OVER, then start -> both hex=1000000, match_done=0, play_en=1 next cycle.
//  Reset at cycle 2 of ROUND_END with score 2-1 -> all outputs at reset values next edge.
//  With MATCH_AUTO_RESTART_EN: after a match win, IDLE with scores 0 exactly 32 cycles later.

Source files
------------

// File: rtl/tug_pkg.sv
// rtl/tug_pkg.sv - shared state encoding and 7-segment patterns for the tug-of-war match logic
package tug_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        ROUND_END,
        MATCH_OVER
    } match_state_t;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - 3-bit score to active-low 7-segment pattern
module seg7_decoder
    import tug_pkg::*;
(
    input  logic [2:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (value)
            3'd0:    seg = SEG_0;
            3'd1:    seg = SEG_1;
            3'd2:    seg = SEG_2;
            3'd3:    seg = SEG_3;
            3'd4:    seg = SEG_4;
            3'd5:    seg = SEG_5;
            3'd6:    seg = SEG_6;
            3'd7:    seg = SEG_7;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/match_controller.sv
// rtl/match_controller.sv - best-of-N tug-of-war match sequencer; MATCH_AUTO_RESTART_EN adds a timed return to IDLE
module match_controller
    import tug_pkg::*;
#(
    parameter int WIN_SCORE   = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       start,
    input  logic       left_win,
    input  logic       right_win,
    output logic       field_reset,
    output logic       play_en,
    output logic [6:0] left_hex,
    output logic [6:0] right_hex,
    output logic       match_done,
    output logic       winner
);

`ifdef MATCH_AUTO_RESTART_EN
    localparam int CNT_SPAN = 8 * HOLD_CYCLES;
`else
    localparam int CNT_SPAN = HOLD_CYCLES;
`endif
    localparam int CNT_W = (CNT_SPAN > 1) ? $clog2(CNT_SPAN + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef MATCH_AUTO_RESTART_EN
    localparam logic [CNT_W-1:0] OVER_LAST = CNT_W'(8 * HOLD_CYCLES - 1);
`endif
    localparam logic [2:0] WIN = 3'(WIN_SCORE);

    match_state_t     state;
    logic [2:0]       left_score;
    logic [2:0]       right_score;
    logic [CNT_W-1:0] hold_cnt;

    // One counter serves both the between-rounds hold and the auto-restart window
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            left_score  <= 3'd0;
            right_score <= 3'd0;
            hold_cnt    <= '0;
            field_reset <= 1'b1;
            play_en     <= 1'b0;
            match_done  <= 1'b0;
            winner      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= PLAY;
                        field_reset <= 1'b0;
                        play_en     <= 1'b1;
                    end
                end

                PLAY: begin
                    if (left_win || right_win) begin
                        field_reset <= 1'b1;
                        play_en     <= 1'b0;
                        hold_cnt    <= '0;
                        state       <= ROUND_END;
                        if (left_win && !right_win && left_score < WIN) begin
                            left_score <= left_score + 3'd1;
                            if ((left_score + 3'd1) == WIN) begin
                                state      <= MATCH_OVER;
                                match_done <= 1'b1;
                                winner     <= 1'b0;
                            end
                        end else if (right_win && !left_win && right_score < WIN) begin
                            right_score <= right_score + 3'd1;
                            if ((right_score + 3'd1) == WIN) begin
                                state      <= MATCH_OVER;
                                match_done <= 1'b1;
                                winner     <= 1'b1;
                            end
                        end
                    end
                end

                ROUND_END: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= PLAY;
                        field_reset <= 1'b0;
                        play_en     <= 1'b1;
                        hold_cnt    <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
                end

                MATCH_OVER: begin
                    if (start) begin
                        state       <= PLAY;
                        left_score  <= 3'd0;
                        right_score <= 3'd0;
                        hold_cnt    <= '0;
                        field_reset <= 1'b0;
                        play_en     <= 1'b1;
                        match_done  <= 1'b0;
                        winner      <= 1'b0;
                    end
`ifdef MATCH_AUTO_RESTART_EN
                    else if (hold_cnt == OVER_LAST) begin
                        state       <= IDLE;
                        left_score  <= 3'd0;
                        right_score <= 3'd0;
                        hold_cnt    <= '0;
                        match_done  <= 1'b0;
                        winner      <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
`endif
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    seg7_decoder u_left_seg (
        .value (left_score),
        .seg   (left_hex)
    );

    seg7_decoder u_right_seg (
        .value (right_score),
        .seg   (right_hex)
    );

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - scoreboard bench for match_controller
module tb_match_controller;

    localparam logic [6:0] H0 = 7'b1000000;
    localparam logic [6:0] H1 = 7'b1111001;
    localparam logic [6:0] H2 = 7'b0100100;
    localparam logic [6:0] H3 = 7'b0110000;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic       left_win = 1'b0;
    logic       right_win = 1'b0;
    logic       field_reset, play_en, match_done, winner;
    logic [6:0] left_hex, right_hex;
    logic [17:0] act;

    typedef struct {
        int          at;
        string       name;
        logic [17:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    match_controller #(.WIN_SCORE(3), .HOLD_CYCLES(4)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .start       (start),
        .left_win    (left_win),
        .right_win   (right_win),
        .field_reset (field_reset),
        .play_en     (play_en),
        .left_hex    (left_hex),
        .right_hex   (right_hex),
        .match_done  (match_done),
        .winner      (winner)
    );

    assign act = {field_reset, play_en, left_hex, right_hex, match_done, winner};

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // winner only carries meaning while match_done is expected high
    always @(negedge Clock) begin
        exp_t        e;
        logic [17:0] mask;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            mask = e.val[1] ? 18'h3ffff : 18'h3fffe;
            checks++;
            if (e.at != cyc)
                $display("FAIL %s: check missed at cycle %0d (now %0d)", e.name, e.at, cyc);
            else if ((act & mask) == (e.val & mask))
                passed++;
            else
                $display("FAIL %s: got fr,pe,lh,rh,md,w=%b required %b", e.name, act, e.val);
        end
    end

    task automatic expect_out(input string nm, input logic fr, input logic pe,
                              input logic [6:0] lh, input logic [6:0] rh,
                              input logic md, input logic w);
        exp_t e;
        e.at   = cyc;
        e.name = nm;
        e.val  = {fr, pe, lh, rh, md, w};
        sb.push_back(e);
    endtask

    task automatic step(input logic s, input logic lw, input logic rw);
        start = s;
        left_win = lw;
        right_win = rw;
        @(posedge Clock);
        #1;
        start = 1'b0;
        left_win = 1'b0;
        right_win = 1'b0;
    endtask

    task automatic idle_n(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    // One non-final round: 4 cycles of hold, then back to PLAY
    task automatic round(input string nm, input logic lw, input logic rw,
                         input logic [6:0] lh, input logic [6:0] rh);
        step(1'b0, lw, rw);
        expect_out({nm, "_round_end"}, 1, 0, lh, rh, 0, 0);
        idle_n(3);
        expect_out({nm, "_hold_last"}, 1, 0, lh, rh, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        expect_out({nm, "_play"}, 0, 1, lh, rh, 0, 0);
    endtask

    initial begin
        idle_n(2);
        expect_out("reset", 1, 0, H0, H0, 0, 0);
        Reset = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        expect_out("idle_ignores_win", 1, 0, H0, H0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        expect_out("start_to_play", 0, 1, H0, H0, 0, 0);

        step(1'b0, 1'b1, 1'b0);
        expect_out("left_round", 1, 0, H1, H0, 0, 0);
        step(1'b1, 1'b0, 1'b1);
        expect_out("hold_ignores_inputs", 1, 0, H1, H0, 0, 0);
        idle_n(2);
        expect_out("hold_last", 1, 0, H1, H0, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        expect_out("hold_done_play", 0, 1, H1, H0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        expect_out("start_in_play_ignored", 0, 1, H1, H0, 0, 0);

        round("draw", 1'b1, 1'b1, H1, H0);
        round("r1", 1'b0, 1'b1, H1, H1);
        step(1'b0, 1'b1, 1'b0);
        expect_out("left_2_1", 1, 0, H2, H1, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        Reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        expect_out("reset_mid_hold", 1, 0, H0, H0, 0, 0);
        Reset = 1'b0;

        step(1'b1, 1'b0, 1'b0);
        expect_out("start_after_reset", 0, 1, H0, H0, 0, 0);
        round("rr1", 1'b0, 1'b1, H0, H1);
        round("rr2", 1'b0, 1'b1, H0, H2);
        round("rl", 1'b1, 1'b0, H1, H2);
        step(1'b0, 1'b0, 1'b1);
        expect_out("right_wins_match", 1, 0, H1, H3, 1, 1);
        step(1'b0, 1'b1, 1'b1);
        expect_out("over_ignores_both", 1, 0, H1, H3, 1, 1);
        step(1'b0, 1'b1, 1'b0);
        expect_out("over_ignores_left", 1, 0, H1, H3, 1, 1);

`ifdef MATCH_AUTO_RESTART_EN
        idle_n(29);
        expect_out("over_window_last", 1, 0, H1, H3, 1, 1);
        step(1'b0, 1'b0, 1'b0);
        expect_out("auto_restart_idle", 1, 0, H0, H0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        expect_out("start_from_idle", 0, 1, H0, H0, 0, 0);
`else
        idle_n(40);
        expect_out("over_persists", 1, 0, H1, H3, 1, 1);
        step(1'b1, 1'b0, 1'b0);
        expect_out("restart_from_over", 0, 1, H0, H0, 0, 0);
`endif

        round("l1", 1'b1, 1'b0, H1, H0);
        round("l2", 1'b1, 1'b0, H2, H0);
        step(1'b0, 1'b1, 1'b0);
        expect_out("left_wins_match", 1, 0, H3, H0, 1, 0);
        step(1'b1, 1'b0, 1'b0);
        expect_out("restart_clears", 0, 1, H0, H0, 0, 0);

        repeat (3) @(posedge Clock);
        while (sb.size() > 0) begin
            checks++;
            $display("FAIL %s: never checked, pending at cycle %0d", sb[0].name, sb[0].at);
            void'(sb.pop_front());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
